// File: rtl/trigger_pkg.sv
// Shared types for the multi-channel trigger unit: FSM state and trigger-mode encodings.
package trigger_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ARM  = 3'd1,
        READY     = 3'd2,
        TRIGGERED = 3'd3,
        HOLDOFF   = 3'd4
    } trig_state_t;

    typedef enum logic [1:0] {
        RISE     = 2'd0,
        FALL     = 2'd1,
        EITHER   = 2'd2,
        LEVEL_HI = 2'd3
    } trig_mode_t;

    function automatic logic edge_event(input trig_mode_t mode, input logic rise,
                                        input logic fall, input logic level);
        logic ev;
        case (mode)
            RISE:     ev = rise;
            FALL:     ev = fall;
            EITHER:   ev = rise | fall;
            default:  ev = level;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/trig_edge_sync.sv
// One comparator channel: metastability chain, previous-sample flop and edge outputs.
module trig_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall,
    output logic o_level
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_last;

    assign w_last = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= w_last;
        end
    end

    assign o_rise  = w_last & ~r_prev;
    assign o_fall  = ~w_last & r_prev;
    assign o_level = w_last;

endmodule

// File: rtl/trigger_unit.sv
// Multi-channel trigger: selects one synchronised comparator, arms after pre-trigger fill,
// latches a trigger (edge, level or forced) and enforces a re-arm holdoff.
module trigger_unit
    import trigger_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 9,
    parameter int unsigned HOLDOFF_W   = 16,
    localparam int unsigned SRC_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_CH-1:0]    i_trig_in,
    input  logic [SRC_W-1:0]     i_trig_src,
    input  logic [1:0]           i_trig_mode,
    input  logic [CNT_W-1:0]     i_trig_pos,
    input  logic [HOLDOFF_W-1:0] i_holdoff,
    input  logic                 i_trig_en,
    input  logic                 i_smpl_stb,
    input  logic                 i_force_trig,
    input  logic                 i_capture_done,
    output logic                 o_triggered,
    output logic                 o_armed,
    output logic [2:0]           o_trig_state
);

    logic [NUM_CH-1:0]    w_rise;
    logic [NUM_CH-1:0]    w_fall;
    logic [NUM_CH-1:0]    w_level;
    logic                 w_event;

    trig_state_t          r_state;
    trig_state_t          w_state_nxt;
    logic [CNT_W:0]       r_pre_cnt;
    logic [CNT_W:0]       w_pre_nxt;
    logic [CNT_W:0]       w_pre_inc;
    logic [CNT_W:0]       w_target;
    logic [HOLDOFF_W-1:0] r_hold_cnt;
    logic [HOLDOFF_W-1:0] w_hold_nxt;
    logic                 r_triggered;
    logic                 r_armed;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        trig_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_async(i_trig_in[g]),
            .o_rise (w_rise[g]),
            .o_fall (w_fall[g]),
            .o_level(w_level[g])
        );
    end

    // Select after edge detection so switching channels never fabricates an edge.
    always_comb begin
        w_event = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_trig_src == SRC_W'(i)) begin
                w_event = edge_event(trig_mode_t'(i_trig_mode), w_rise[i], w_fall[i],
                                     w_level[i]);
            end
        end
    end

    // DEPTH - trig_pos; trig_pos == 0 needs a full DEPTH of strobes.
    assign w_target  = {1'b1, {CNT_W{1'b0}}} - {1'b0, i_trig_pos};
    assign w_pre_inc = r_pre_cnt + {{CNT_W{1'b0}}, i_smpl_stb};

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre_cnt;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            IDLE: begin
                w_pre_nxt = '0;
                if (i_trig_en) w_state_nxt = WAIT_ARM;
            end
            WAIT_ARM: begin
                if (!i_trig_en) begin
                    w_state_nxt = IDLE;
                    w_pre_nxt   = '0;
                end else if (i_force_trig) begin
                    w_state_nxt = TRIGGERED;
                end else begin
                    w_pre_nxt = w_pre_inc;
                    if (w_pre_inc >= w_target) w_state_nxt = READY;
                end
            end
            READY: begin
                if (!i_trig_en) begin
                    w_state_nxt = IDLE;
                    w_pre_nxt   = '0;
                end else if (w_event || i_force_trig) begin
                    w_state_nxt = TRIGGERED;
                end
            end
            TRIGGERED: begin
                if (i_capture_done) begin
                    w_pre_nxt = '0;
                    if (i_holdoff == '0) begin
                        w_state_nxt = i_trig_en ? WAIT_ARM : IDLE;
                    end else begin
                        w_state_nxt = HOLDOFF;
                        w_hold_nxt  = i_holdoff;
                    end
                end
            end
            HOLDOFF: begin
                if (!i_trig_en || r_hold_cnt <= HOLDOFF_W'(1)) begin
                    w_state_nxt = i_trig_en ? WAIT_ARM : IDLE;
                    w_hold_nxt  = '0;
                    w_pre_nxt   = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt - HOLDOFF_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pre_nxt   = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_pre_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_triggered <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pre_cnt   <= w_pre_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_triggered <= (w_state_nxt == TRIGGERED);
            r_armed     <= (w_state_nxt == READY);
        end
    end

    assign o_triggered  = r_triggered;
    assign o_armed      = r_armed;
    assign o_trig_state = r_state;

endmodule
